// File: rtl/wb_xclk_pkg.sv
// Shared types and default widths for the Wishbone cross-clock watchdog.
package wb_xclk_pkg;

  localparam int unsigned WB_AW   = 32;
  localparam int unsigned WB_DW   = 32;
  localparam int unsigned STATS_W = 16;

  // IDLE: nothing outstanding; BUSY: requests in flight;
  // ABORT: CYC held low toward the bridge; WAIT: waiting for the master to drop CYC.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2,
    WAIT  = 2'd3
  } wd_state_t;

  // True in the states where requests and responses flow through.
  function automatic logic is_live(input wd_state_t s);
    return (s == IDLE) || (s == BUSY);
  endfunction

endpackage

// File: rtl/wb_xclk_timer.sv
// Clearable saturating up-counter with a terminal-count flag.
// Shared by the no-progress timeout and the abort hold.
module wb_xclk_timer #(
  parameter int unsigned  W     = 10,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic i_wb_clk,
  input  logic i_reset,
  input  logic clr,
  input  logic en,
  output logic done_c
);

  logic [W-1:0] count_q;

  // Count up while enabled, stop at LIMIT; clear has priority.
  always_ff @(posedge i_wb_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != LIMIT)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign done_c = (count_q == LIMIT);

endmodule

// File: rtl/wb_xclk_watchdog.sv
// Wishbone guard stage in front of the cross-clock bridge: forwards requests,
// bounds outstanding transactions and aborts hung ones after a timeout.
// Define WB_XCLK_WATCHDOG_STATS_EN to add the o_timeouts abort counter.
module wb_xclk_watchdog
  import wb_xclk_pkg::*;
#(
  parameter int unsigned AW         = WB_AW,
  parameter int unsigned DW         = WB_DW,
  parameter int unsigned LGMAXOUT   = 5,   // limit is 2^LGMAXOUT-1 outstanding
  parameter int unsigned LGTIMEOUT  = 10,  // timeout after 2^LGTIMEOUT-1 idle cycles
  parameter int unsigned ABORT_HOLD = 8    // must be at least 1
) (
  input  logic            i_wb_clk,
  input  logic            i_reset,
  // master side
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [DW-1:0]   i_wb_data,
  input  logic [DW/8-1:0] i_wb_sel,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic            o_wb_err,
  output logic [DW-1:0]   o_wb_data,
  // bridge side
  output logic            o_xb_cyc,
  output logic            o_xb_stb,
  output logic            o_xb_we,
  output logic [AW-1:0]   o_xb_addr,
  output logic [DW-1:0]   o_xb_data,
  output logic [DW/8-1:0] o_xb_sel,
  input  logic            i_xb_stall,
  input  logic            i_xb_ack,
  input  logic            i_xb_err,
  input  logic [DW-1:0]   i_xb_data
`ifdef WB_XCLK_WATCHDOG_STATS_EN
  ,
  output logic [STATS_W-1:0] o_timeouts
`endif
);

  localparam int unsigned CNT_W  = LGMAXOUT;
  localparam int unsigned HOLD_W = $clog2(ABORT_HOLD + 1);

  wd_state_t        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q;

  logic live, full, accept, resp, timeout;
  logic tmr_clr, tmr_en, tmr_done;
  logic hold_clr, hold_en, hold_done;

  // Zero-latency datapath pass-through.
  assign o_xb_we   = i_wb_we;
  assign o_xb_addr = i_wb_addr;
  assign o_xb_data = i_wb_data;
  assign o_xb_sel  = i_wb_sel;
  assign o_wb_data = i_xb_data;

  // Request forwarding and handshake decode; reset forces the idle bus view.
  assign live       = !i_reset && is_live(state_q);
  assign full       = (count_q == '1);
  assign o_xb_cyc   = i_wb_cyc && live;
  assign o_xb_stb   = o_xb_cyc && i_wb_stb && !full;
  assign o_wb_stall = i_reset || i_xb_stall || full || !live;
  assign accept     = o_xb_stb && !i_xb_stall;

  // Responses only count while live with something outstanding.
  assign resp     = (i_xb_ack || i_xb_err) && o_xb_cyc && (count_q != '0);
  assign o_wb_ack = resp && i_xb_ack && !i_xb_err;
  assign o_wb_err = (resp && i_xb_err) || err_q;

  // No-progress timer: restarts on any handshake, idles at zero when empty.
  assign tmr_clr = accept || resp || (count_q == '0) || !i_wb_cyc;
  assign tmr_en  = (state_q == BUSY);
  assign timeout = (state_q == BUSY) && i_wb_cyc && tmr_done && !accept && !resp;

  wb_xclk_timer #(
    .W (LGTIMEOUT)
  ) u_timeout (
    .i_wb_clk (i_wb_clk),
    .i_reset  (i_reset),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .done_c   (tmr_done)
  );

  // Abort hold: done on the last of ABORT_HOLD cycles spent in ABORT.
  assign hold_clr = (state_q != ABORT);
  assign hold_en  = (state_q == ABORT);

  wb_xclk_timer #(
    .W     (HOLD_W),
    .LIMIT (HOLD_W'(ABORT_HOLD - 1))
  ) u_hold (
    .i_wb_clk (i_wb_clk),
    .i_reset  (i_reset),
    .clr      (hold_clr),
    .en       (hold_en),
    .done_c   (hold_done)
  );

  // State and outstanding-count registers; err_q is the one-shot abort error.
  always_ff @(posedge i_wb_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= timeout;
    end
  end

  // Next state and outstanding count.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE, BUSY: begin
        if (!i_wb_cyc) begin
          count_d = '0;
          state_d = IDLE;
        end else if (timeout) begin
          count_d = '0;
          state_d = ABORT;
        end else begin
          count_d = count_q + CNT_W'(accept) - CNT_W'(resp);
          state_d = (count_d == '0) ? IDLE : BUSY;
        end
      end
      ABORT: begin
        count_d = '0;
        if (hold_done) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        count_d = '0;
        if (!i_wb_cyc) begin
          state_d = IDLE;
        end
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef WB_XCLK_WATCHDOG_STATS_EN
  // Saturating count of entries into ABORT.
  always_ff @(posedge i_wb_clk or posedge i_reset) begin
    if (i_reset) begin
      o_timeouts <= '0;
    end else if (timeout && (o_timeouts != '1)) begin
      o_timeouts <= o_timeouts + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_wb_xclk_watchdog.sv
// Self-checking bench for wb_xclk_watchdog: directed vector table, corner-case
// sequences and a randomized run against a transaction-level reference model.
module tb_wb_xclk_watchdog;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned SW      = DW / 8;
  localparam int          MAXOUT  = 31;
  localparam longint      TMO     = 1023;
  localparam longint      HOLD    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata;
  logic [SW-1:0] wb_sel;
  logic          wb_stall, wb_ack, wb_err;
  logic [DW-1:0] wb_rdata;
  logic          xb_cyc, xb_stb, xb_we;
  logic [AW-1:0] xb_addr;
  logic [DW-1:0] xb_wdata;
  logic [SW-1:0] xb_sel;
  logic          xb_stall, xb_ack, xb_err;
  logic [DW-1:0] xb_rdata;
`ifdef WB_XCLK_WATCHDOG_STATS_EN
  logic [15:0]   timeouts;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_xclk_watchdog dut (
    .i_wb_clk   (clk),
    .i_reset    (rst),
    .i_wb_cyc   (wb_cyc),
    .i_wb_stb   (wb_stb),
    .i_wb_we    (wb_we),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_wdata),
    .i_wb_sel   (wb_sel),
    .o_wb_stall (wb_stall),
    .o_wb_ack   (wb_ack),
    .o_wb_err   (wb_err),
    .o_wb_data  (wb_rdata),
    .o_xb_cyc   (xb_cyc),
    .o_xb_stb   (xb_stb),
    .o_xb_we    (xb_we),
    .o_xb_addr  (xb_addr),
    .o_xb_data  (xb_wdata),
    .o_xb_sel   (xb_sel),
    .i_xb_stall (xb_stall),
    .i_xb_ack   (xb_ack),
    .i_xb_err   (xb_err),
    .i_xb_data  (xb_rdata)
`ifdef WB_XCLK_WATCHDOG_STATS_EN
    ,
    .o_timeouts (timeouts)
`endif
  );

  // Directed vector: inputs {cyc,stb,xstall,ack,err}, bridge read data,
  // expected {xb_cyc,xb_stb,wb_stall,wb_ack,wb_err}.
  typedef struct {
    logic [4:0]  in;
    logic [31:0] rdata;
    logic [4:0]  exp;
  } vec_t;

  vec_t tbl[14];

  // Reference model state: outstanding queue, progress timestamps, abort phase.
  int unsigned q[$];
  int          mode;        // 0 live, 1 aborting, 2 waiting for cyc drop
  longint      mc;          // model cycle number
  longint      last_clr;    // last cycle that restarted the no-progress clock
  longint      abort_first; // first cycle spent aborting
  int          m_tmo;

  function automatic vec_t mk(input logic [4:0] in, input logic [31:0] rd, input logic [4:0] ex);
    vec_t v;
    v.in = in; v.rdata = rd; v.exp = ex;
    return v;
  endfunction

  function automatic logic [4:0] outs();
    return {xb_cyc, xb_stb, wb_stall, wb_ack, wb_err};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [4:0] v);
    {wb_cyc, wb_stb, xb_stall, xb_ack, xb_err} = v;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(5'b00000);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Count accepts until the block stalls (bounded).
  task automatic fill_count(output int acc);
    bit stop;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      drive(5'b11000);
      settle();
      if (!wb_stall && xb_stb) acc++;
      stop = wb_stall;
      tick();
      if (stop) break;
    end
  endtask

  // One request left unanswered until the watchdog fires.
  task automatic run_timeout(input bit early_drop);
    int lat, stall_run;
    bit bad;
    drive(5'b11000);
    tick();
    drive(5'b10000);
    lat = 0;
    for (int k = 1; k <= 1100; k++) begin
      settle();
      if (wb_err) begin
        lat = k;
        break;
      end
      tick();
    end
    check("tmo_latency", 128'(lat), 128'(1025));
    check("tmo_abort_entry", 128'(outs()), 128'(5'b00101));
    if (!early_drop) begin
      bad = 1'b0;
      for (int h = 1; h <= 8; h++) begin
        tick();
        drive((h == 3) ? 5'b10010 : 5'b10000);
        settle();
        if (h == 3) check("late_ack_absorbed", 128'(outs()), 128'(5'b00100));
        if (outs() != 5'b00100) bad = 1'b1;
      end
      check("abort_hold_outs", 128'(bad), 128'(0));
      tick();
      drive(5'b00000);
      settle();
      check("wait_drop", 128'(outs()), 128'(5'b00100));
      tick();
      drive(5'b11000);
      settle();
      check("idle_after_abort", 128'(outs()), 128'(5'b11000));
      tick();
      drive(5'b00000);
      tick();
    end else begin
      stall_run = 1;
      for (int i = 0; i < 20; i++) begin
        tick();
        drive(5'b00000);
        settle();
        if (!wb_stall) break;
        stall_run++;
      end
      check("abort_hold_len", 128'(stall_run), 128'(HOLD + 1));
      tick();
    end
  endtask

  // Randomized cycles checked against the reference model (rates per 10000).
  task automatic run_random(input int n, input int drop_r, input int ack_r, input int err_r);
    logic       c, s, xs_in, a, e;
    logic       live, xc, fl, xs, st, acc, rsp, wa, we_o, was_empty;
    logic [4:0] ex;
    for (int i = 0; i < n; i++) begin
      c     = ($urandom_range(0, 9999) >= drop_r);
      s     = 1'($urandom_range(0, 1));
      xs_in = ($urandom_range(0, 3) == 0);
      a     = ($urandom_range(0, 9999) < ack_r);
      e     = ($urandom_range(0, 9999) < err_r);
      drive({c, s, xs_in, a, e});
      wb_we    = 1'($urandom_range(0, 1));
      wb_addr  = $urandom;
      wb_wdata = $urandom;
      wb_sel   = 4'($urandom_range(0, 15));
      xb_rdata = $urandom;
      settle();
      live = (mode == 0);
      xc   = c && live;
      fl   = (q.size() == MAXOUT);
      xs   = xc && s && !fl;
      st   = xs_in || fl || !live;
      acc  = xs && !xs_in;
      rsp  = (a || e) && xc && (q.size() != 0);
      wa   = rsp && a && !e;
      we_o = (rsp && e) || (mode == 1 && mc == abort_first);
      ex   = {xc, xs, st, wa, we_o};
      check("random", 128'({outs(), xb_we, xb_sel, xb_addr, xb_wdata, wb_rdata}),
            128'({ex, wb_we, wb_sel, wb_addr, wb_wdata, xb_rdata}));
      if (mode == 0) begin
        if (!c) begin
          q.delete();
          last_clr = mc;
        end else if (q.size() != 0 && !acc && !rsp && (mc - last_clr - 1) >= TMO) begin
          q.delete();
          mode = 1;
          abort_first = mc + 1;
          if (m_tmo < 65535) m_tmo++;
        end else begin
          was_empty = (q.size() == 0);
          if (rsp) void'(q.pop_front());
          if (acc) q.push_back(wb_addr);
          if (acc || rsp || was_empty) last_clr = mc;
        end
      end else if (mode == 1) begin
        if (mc == abort_first + HOLD - 1) mode = 2;
      end else if (!c) begin
        mode = 0;
        last_clr = mc;
      end
      mc++;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb time limit");
  end

  initial begin
    int acc, viol, first_stall;

    wb_we = 1'b0; wb_addr = '0; wb_wdata = '0; wb_sel = '1; xb_rdata = '0;
    rst = 1'b1;
    drive(5'b11010);
    #2;
    check("reset_outs", 128'(outs()), 128'(5'b00100));

    // Directed table from IDLE.
    tbl[0]  = mk(5'b11000, 32'h0,        5'b11000);
    tbl[1]  = mk(5'b10000, 32'h0,        5'b10000);
    tbl[2]  = mk(5'b10000, 32'h0,        5'b10000);
    tbl[3]  = mk(5'b10010, 32'hDEADBEEF, 5'b10010);
    tbl[4]  = mk(5'b10010, 32'h12345678, 5'b10000);
    tbl[5]  = mk(5'b11100, 32'h0,        5'b11100);
    tbl[6]  = mk(5'b11000, 32'h0,        5'b11000);
    tbl[7]  = mk(5'b11000, 32'h0,        5'b11000);
    tbl[8]  = mk(5'b11001, 32'h0,        5'b11001);
    tbl[9]  = mk(5'b10011, 32'h0,        5'b10001);
    tbl[10] = mk(5'b10010, 32'hCAFEF00D, 5'b10010);
    tbl[11] = mk(5'b10010, 32'h0,        5'b10000);
    tbl[12] = mk(5'b01000, 32'h0,        5'b00000);
    tbl[13] = mk(5'b00100, 32'h0,        5'b00100);
    do_reset();
    wb_addr = 32'h100;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].in);
      xb_rdata = tbl[i].rdata;
      settle();
      check($sformatf("vec%0d", i), 128'({outs(), wb_rdata, xb_addr}),
            128'({tbl[i].exp, tbl[i].rdata, 32'h100}));
      tick();
    end

    // Back-to-back writes with no acks: fills to the limit and stalls.
    do_reset();
    wb_we = 1'b1;
    acc = 0; viol = 0; first_stall = -1;
    for (int i = 0; i < 40; i++) begin
      drive(5'b11000);
      settle();
      if (acc == MAXOUT && xb_stb) viol++;
      if (xb_stb && !xb_stall) acc++;
      if (wb_stall && first_stall < 0) first_stall = i;
      tick();
    end
    check("burst_accepted", 128'(acc), 128'(MAXOUT));
    check("burst_no_stb_full", 128'(viol), 128'(0));
    check("burst_stall_at", 128'(first_stall), 128'(MAXOUT));
    drive(5'b00000);
    tick();
    drive(5'b11000);
    settle();
    check("drop_clears_full", 128'(outs()), 128'(5'b11000));
    tick();

    // Accept and ack together at count 5.
    do_reset();
    wb_we = 1'b0;
    repeat (5) begin
      drive(5'b11000);
      tick();
    end
    drive(5'b11010);
    settle();
    check("acc_ack_same_cycle", 128'(outs()), 128'(5'b11010));
    tick();
    fill_count(acc);
    check("count_held_5", 128'(acc), 128'(MAXOUT - 5));

    // Master drops cyc with 3 outstanding; late ack is ignored.
    do_reset();
    repeat (3) begin
      drive(5'b11000);
      tick();
    end
    drive(5'b00000);
    settle();
    check("drop_cyc_falls", 128'(outs()), 128'(5'b00000));
    tick();
    drive(5'b10010);
    settle();
    check("ack_after_drop", 128'(outs()), 128'(5'b10000));
    tick();
    fill_count(acc);
    check("count_zero_after_drop", 128'(acc), 128'(MAXOUT));

    // Two timeouts.
    do_reset();
    run_timeout(1'b0);
    run_timeout(1'b1);
`ifdef WB_XCLK_WATCHDOG_STATS_EN
    check("stats_two", 128'(timeouts), 128'(2));
`endif

    // Asynchronous reset in the middle of BUSY.
    drive(5'b11000);
    tick();
    drive(5'b11010);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outs", 128'(outs()), 128'(5'b00100));
`ifdef WB_XCLK_WATCHDOG_STATS_EN
    check("stats_reset", 128'(timeouts), 128'(0));
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(5'b10000);
    settle();
    check("post_reset_idle", 128'(outs()), 128'(5'b10000));
    tick();

    // Randomized run against the reference model.
    do_reset();
    q.delete();
    mode = 0; mc = 0; last_clr = 0; abort_first = -1; m_tmo = 0;
    run_random(3000, 100, 2500, 200);
    run_random(6000, 2, 3, 1);
`ifdef WB_XCLK_WATCHDOG_STATS_EN
    check("stats_random", 128'(timeouts), 128'(m_tmo));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_xclk_watchdog.md
Name: wb_xclk_watchdog

Overview:
- Pipelined Wishbone guard stage directly upstream of the cross-clock bridge, in the i_wb_clk domain.
- Passes requests through to the bridge.
- Bounds the number of outstanding transactions.
- Ends hung transactions after a timeout: returns one bus error to the master, drops CYC toward the bridge so it aborts, and absorbs late acks.

Parameters:
- AW, 32, address width
- DW, 32, data width
- LGMAXOUT, 5, log2 of maximum outstanding requests; limit is 2^LGMAXOUT-1
- LGTIMEOUT, 10, timeout counter width; timeout is 2^LGTIMEOUT-1 cycles with no ack progress
- ABORT_HOLD, 8, cycles CYC is held low toward the bridge after an abort

Ports:
- i_wb_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  master request
- i_wb_addr  in  AW  master address
- i_wb_data  in  DW  master write data
- i_wb_sel  in  DW/8  master byte select
- o_wb_stall, o_wb_ack, o_wb_err  out  1 each  master response
- o_wb_data  out  DW  master read data
- o_xb_cyc, o_xb_stb, o_xb_we  out  1 each  bridge request
- o_xb_addr  out  AW  bridge address
- o_xb_data  out  DW  bridge write data
- o_xb_sel  out  DW/8  bridge byte select
- i_xb_stall, i_xb_ack, i_xb_err  in  1 each  bridge response
- i_xb_data  in  DW  bridge read data

Behaviour:
- Clock and reset: reset i_reset, asynchronous, active-high; clock i_wb_clk.
- Reset values: state=IDLE, outstanding count=0, timer=0, hold counter=0, o_wb_ack=0, o_wb_err=0.
- o_xb_cyc, o_xb_stb and o_wb_stall are combinational.
  - During reset they read 0, 0 and 1 respectively.
- Datapath: o_xb_we/addr/data/sel are combinational pass-throughs; o_wb_data = i_xb_data; zero added latency.
- States:
  - IDLE: no outstanding requests.
  - BUSY: count>0.
  - ABORT: timeout fired; holding CYC low toward the bridge.
  - WAIT: abort hold done; waiting for the master to drop CYC.
- Forwarding:
  - o_xb_cyc = i_wb_cyc && state in {IDLE, BUSY}.
  - o_xb_stb = o_xb_cyc && i_wb_stb && !full.
- Stall: o_wb_stall = i_xb_stall || full || state in {ABORT, WAIT}.
- Full: full = (count == 2^LGMAXOUT-1).
- Accept: accept = o_xb_stb && !i_xb_stall.
- Response: resp = (i_xb_ack || i_xb_err) && state in {IDLE, BUSY} && i_wb_cyc.
- Count update:
  - Count +1 on accept and -1 on resp; when both occur in the same cycle, the count is unchanged.
  - A resp with count==0 is ignored; it is not forwarded and does not underflow.
- Master response: o_wb_ack = resp && i_xb_ack && !i_xb_err; o_wb_err = resp && i_xb_err.
  - These are combinational, same cycle as the bridge response.
- Timer:
  - Clears on accept, on resp, or when count==0.
  - Otherwise increments while in BUSY.
  - Reaching all-ones in BUSY is a timeout.
- Timeout, on the cycle of entry to ABORT:
  - Count is cleared.
  - A one-cycle registered o_wb_err pulse is issued on the next cycle.
  - This pulse is ORed into o_wb_err; it overrides the ack path, which is already gated.
- ABORT:
  - o_xb_cyc=0.
  - All i_xb_ack/i_xb_err are dropped.
  - The hold counter counts ABORT_HOLD cycles, then the block moves to WAIT.
- WAIT: remains until i_wb_cyc==0, then moves to IDLE.
- Master drops i_wb_cyc in IDLE/BUSY: count and timer clear the same cycle; state goes to IDLE; o_xb_cyc falls combinationally.
- Reset mid-transaction: all state returns to reset values immediately; no err is issued.
- Transitions:
  - IDLE→BUSY on an accept with no simultaneous completing resp.
  - BUSY→IDLE when the count reaches 0.

Optional Feature:
- Macro: WB_XCLK_WATCHDOG_STATS_EN.
- With the macro defined, the block adds output port o_timeouts[15:0].
  - It is a saturating count of ABORT entries.
  - It resets to 0 and holds at 16'hFFFF.
- Without the macro, the port and its counter are absent.

Decomposition:
- Shared package wb_xclk_pkg holds:
  - the state enum (IDLE, BUSY, ABORT, WAIT);
  - default width constants (AW, DW);
  - stats counter width 16.
- One natural sub-module, wb_xclk_timer: clearable saturating up-counter with a terminal-count flag, reused for the timeout and the abort hold.

Test Plan:
- Single read: stb, addr=0x100; bridge acks 3 cycles later with data 0xDEADBEEF -> o_wb_ack for one cycle with o_wb_data=0xDEADBEEF; count returns 0; state IDLE.
- Burst of 40 back-to-back writes, bridge never stalls and never acks -> 31 accepted, then o_wb_stall=1; o_xb_stb is never asserted while full.
- Simultaneous accept and ack while count=5 -> count stays 5; ack forwarded.
- No ack for 1023 cycles after one request -> one-cycle o_wb_err on the next cycle; o_xb_cyc=0 for 8 cycles; a late i_xb_ack at hold cycle 3 is not forwarded; block reaches IDLE after the master drops cyc.
- Master drops i_wb_cyc with count=3, then a bridge ack arrives -> o_xb_cyc falls the same cycle; no o_wb_ack; count=0.
- With WB_XCLK_WATCHDOG_STATS_EN defined: two timeouts -> o_timeouts=2. Async reset asserted mid-BUSY -> all outputs at reset values before the next clock edge and o_timeouts=0.
